// File: rtl/accum_drain_if.sv
// Read port to the accumulator column plus the valid/ready output stream.
interface accum_drain_if #(
  parameter int AW         = 10,
  parameter int DATA_WIDTH = 8
);
  logic                         rd_en;
  logic [AW-1:0]                rd_addr;
  logic signed [DATA_WIDTH-1:0] rd_data;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_WIDTH-1:0] out_data;

  modport master (
    output rd_en, rd_addr, out_valid, out_data,
    input  rd_data, out_ready
  );

  modport slave (
    input  rd_en, rd_addr, out_valid, out_data,
    output rd_data, out_ready
  );
endinterface

// File: rtl/accum_drain.sv
// Drains a row range of one accumulator column into a valid/ready stream; ACCUM_DRAIN_CLEAR_EN adds a column clear.
// Latency: start -> first rd_en next cycle, first out_valid three cycles after start.
// Backpressure: reads are credit-gated so the 4-entry FIFO absorbs stalls without overflow.

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module accum_drain #(
  parameter int  DATA_WIDTH     = 8,
  parameter int  MAX_OUT_ROWS   = 128,
  parameter int  MAX_OUT_COLS   = 128,
  parameter int  SYS_ARR_COLS   = 16,
  localparam int NUM_ACCUM_ROWS = MAX_OUT_ROWS * (MAX_OUT_COLS / SYS_ARR_COLS),
  localparam int AW             = $clog2(NUM_ACCUM_ROWS)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [AW-1:0]  base_addr,
  input  logic [AW:0]    num_rows,
  output logic           busy,
  output logic           done,
  output logic           clear,
  accum_drain_if.master  bus
);
  localparam int FIFO_DEPTH = 4;
  localparam int FCW        = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    FLUSH,
`ifdef ACCUM_DRAIN_CLEAR_EN
    CLR,
`endif
    DONE
  } state_t;

  state_t                  state, next_state;
  logic [AW:0]             num_rows_q, issued;
  logic                    rd_en_q, rd_vld_d;
  logic [AW-1:0]           rd_addr_q;
  logic [FCW-1:0]          fifo_count, credit_used;
  logic                    fifo_empty;
  logic [DATA_WIDTH-1:0]   fifo_dout;
  logic [1:0]              inflight;
  logic                    issue, pop, drained;

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
    return (a == AW'(NUM_ACCUM_ROWS - 1)) ? '0 : a + AW'(1);
  endfunction

  assign inflight    = {1'b0, rd_en_q} + {1'b0, rd_vld_d};
  assign credit_used = fifo_count + FCW'(inflight);
  assign pop         = bus.out_valid && bus.out_ready;
  // Final word counts as drained on the cycle it handshakes, not the cycle after.
  assign drained     = (inflight == 2'd0) &&
                       (fifo_empty || ((fifo_count == FCW'(1)) && pop));

  always_comb begin
    issue = 1'b0;
    if (state == IDLE)
      issue = start && (num_rows != '0);
    else if (state == READ)
      issue = (issued < num_rows_q) && (credit_used < FCW'(FIFO_DEPTH));
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (start) next_state = READ;
      // A zero-length drain still spends one cycle in READ so done lands two cycles after start.
      READ:  if (issued == num_rows_q) next_state = (num_rows_q == '0) ? DONE : FLUSH;
`ifdef ACCUM_DRAIN_CLEAR_EN
      FLUSH: if (drained) next_state = CLR;
      CLR:   next_state = DONE;
`else
      FLUSH: if (drained) next_state = DONE;
`endif
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      num_rows_q <= '0;
      issued     <= '0;
      rd_en_q    <= 1'b0;
      rd_vld_d   <= 1'b0;
      rd_addr_q  <= '0;
    end else begin
      state    <= next_state;
      rd_en_q  <= issue;
      rd_vld_d <= rd_en_q;
      if (state == IDLE) begin
        if (start) begin
          num_rows_q <= num_rows;
          issued     <= issue ? (AW+1)'(1) : '0;
          if (issue) rd_addr_q <= base_addr;
        end
      end else if (issue) begin
        issued    <= issued + (AW+1)'(1);
        rd_addr_q <= next_addr(rd_addr_q);
      end
    end
  end

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .CW    (FCW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rd_vld_d),
    .din   (bus.rd_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = fifo_dout;
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);
`ifdef ACCUM_DRAIN_CLEAR_EN
  assign clear         = (state == CLR);
`else
  assign clear         = 1'b0;
`endif
endmodule

// File: tb/tb_accum_drain.sv
// Directed bench for accum_drain; reacts to ACCUM_DRAIN_CLEAR_EN the same way the design does.
module tb_accum_drain;
  localparam int NUM = 1024;
  localparam int AW  = 10;

  logic          clk = 1'b0;
  logic          rst_n, start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   num_rows;
  logic          busy, done, clear;

  always #5 clk = ~clk;

  accum_drain_if #(.AW(AW), .DATA_WIDTH(8)) bus();

  accum_drain #(
    .DATA_WIDTH(8), .MAX_OUT_ROWS(128), .MAX_OUT_COLS(128), .SYS_ARR_COLS(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .num_rows(num_rows), .busy(busy), .done(done), .clear(clear), .bus(bus)
  );

  // Column model: one-cycle read latency.
  logic signed [7:0] mem [NUM];
  logic signed [7:0] rd_q;
  always @(posedge clk) if (bus.rd_en) rd_q <= mem[bus.rd_addr];
  assign bus.rd_data = rd_q;

  int n_vec = 0;
  int n_err = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input int b, input int n);
    base_addr = b[AW-1:0];
    num_rows  = n[AW:0];
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; base_addr = '0; num_rows = '0; bus.out_ready = 1'b0;
    step(); step();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_vec++; if (clear !== 1'b0) begin n_err++; $display("FAIL reset_clear: got %b want 0", clear); end
    n_vec++; if (bus.rd_en !== 1'b0) begin n_err++; $display("FAIL reset_rd_en: got %b want 0", bus.rd_en); end
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_vec++; if (bus.rd_addr !== '0) begin n_err++; $display("FAIL reset_rd_addr: got %0d want 0", bus.rd_addr); end
    n_vec++; if (bus.out_data !== 8'sd0) begin n_err++; $display("FAIL reset_out_data: got %0d want 0", bus.out_data); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic signed [7:0] ew [4] = '{8'sd5, -8'sd3, 8'sd127, 8'sh80};
    bus.out_ready = 1'b1;
    kick(0, 4);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_k1: got %b want 1", busy); end
    n_vec++; if (bus.rd_en !== 1'b1) begin n_err++; $display("FAIL basic_rd_en_k1: got %b want 1", bus.rd_en); end
    n_vec++; if (bus.rd_addr !== 10'd0) begin n_err++; $display("FAIL basic_rd_addr_k1: got %0d want 0", bus.rd_addr); end
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_k1: got %b want 0", bus.out_valid); end
    step();
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_k2: got %b want 0", bus.out_valid); end
    step();
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid_w%0d: got %b want 1", i, bus.out_valid); end
      n_vec++; if (bus.out_data !== ew[i]) begin n_err++; $display("FAIL basic_data_w%0d: got %0d want %0d", i, bus.out_data, ew[i]); end
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL basic_early_done_w%0d: got %b want 0", i, done); end
      step();
    end
`ifdef ACCUM_DRAIN_CLEAR_EN
    n_vec++; if (clear !== 1'b1) begin n_err++; $display("FAIL basic_clear: got %b want 1", clear); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL basic_done_during_clear: got %b want 0", done); end
    step();
`endif
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL basic_done: got %b want 1", done); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_done: got %b want 1", busy); end
    step();
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse: got %b want 0", done); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    int got = 0, reads = 0, maxo = 0, cyc = 0;
    bit fin = 1'b0, pv = 1'b0, pr = 1'b0;
    logic signed [7:0] pd = '0;
    bus.out_ready = 1'b1;
    kick(10, 8);
    while (!fin && cyc < 80) begin
      bus.out_ready = (cyc % 2 == 0);
      if (bus.rd_en === 1'b1) begin
        n_vec++; if (bus.rd_addr !== 10'(10 + reads)) begin n_err++; $display("FAIL bp_rd_addr_%0d: got %0d want %0d", reads, bus.rd_addr, 10 + reads); end
        reads++;
      end
      if (reads - got > maxo) maxo = reads - got;
      if (pv && !pr) begin
        n_vec++; if (bus.out_valid !== 1'b1 || bus.out_data !== pd) begin n_err++; $display("FAIL bp_stall_hold: got valid %b data %0d want valid 1 data %0d", bus.out_valid, bus.out_data, pd); end
      end
      if (bus.out_valid === 1'b1 && bus.out_ready) begin
        n_vec++; if (bus.out_data !== mem[10 + got]) begin n_err++; $display("FAIL bp_word_%0d: got %0d want %0d", got, bus.out_data, mem[10 + got]); end
        got++;
      end
      pv = bus.out_valid; pr = bus.out_ready; pd = bus.out_data;
      if (done === 1'b1) fin = 1'b1;
      step();
      cyc++;
    end
    n_vec++; if (!fin) begin n_err++; $display("FAIL bp_timeout: got no done want done within 80 cycles"); end
    n_vec++; if (got != 8) begin n_err++; $display("FAIL bp_word_count: got %0d want 8", got); end
    n_vec++; if (reads != 8) begin n_err++; $display("FAIL bp_read_count: got %0d want 8", reads); end
    n_vec++; if (maxo > 4) begin n_err++; $display("FAIL bp_occupancy: got %0d want <= 4", maxo); end
    bus.out_ready = 1'b1;
    step();
  endtask

  task automatic test_wrap();
    int ea [4] = '{1022, 1023, 0, 1};
    int reads = 0, got = 0, cyc = 0;
    bit fin = 1'b0;
    bus.out_ready = 1'b1;
    kick(NUM - 2, 4);
    while (!fin && cyc < 40) begin
      if (bus.rd_en === 1'b1) begin
        n_vec++; if (reads > 3 || bus.rd_addr !== 10'(ea[reads & 3])) begin n_err++; $display("FAIL wrap_rd_addr_%0d: got %0d want %0d", reads, bus.rd_addr, ea[reads & 3]); end
        reads++;
      end
      if (bus.out_valid === 1'b1) begin
        n_vec++; if (got > 3 || bus.out_data !== mem[ea[got & 3]]) begin n_err++; $display("FAIL wrap_word_%0d: got %0d want %0d", got, bus.out_data, mem[ea[got & 3]]); end
        got++;
      end
      if (done === 1'b1) fin = 1'b1;
      step();
      cyc++;
    end
    n_vec++; if (!fin || reads != 4 || got != 4) begin n_err++; $display("FAIL wrap_counts: got done %b reads %0d words %0d want 1 4 4", fin, reads, got); end
    step();
  endtask

  task automatic test_zero();
    bus.out_ready = 1'b1;
    kick(5, 0);
    n_vec++; if (done !== 1'b0 || bus.rd_en !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL zero_k1: got done %b rd_en %b busy %b want 0 0 1", done, bus.rd_en, busy); end
    step();
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL zero_done_k2: got %b want 1", done); end
    n_vec++; if (bus.rd_en !== 1'b0 || bus.out_valid !== 1'b0) begin n_err++; $display("FAIL zero_quiet_k2: got rd_en %b valid %b want 0 0", bus.rd_en, bus.out_valid); end
    step();
    n_vec++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL zero_k3: got done %b busy %b want 0 0", done, busy); end
  endtask

  task automatic test_reset_mid();
    int got = 0, cyc = 0, dones = 0;
    bus.out_ready = 1'b1;
    kick(20, 8);
    while (got < 3 && cyc < 20) begin
      if (bus.out_valid === 1'b1) got++;
      step();
      cyc++;
    end
    n_vec++; if (got != 3) begin n_err++; $display("FAIL rmid_progress: got %0d want 3", got); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (busy !== 1'b0 || done !== 1'b0 || clear !== 1'b0 || bus.rd_en !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL rmid_ctrl: got busy %b done %b clear %b rd_en %b valid %b want all 0", busy, done, clear, bus.rd_en, bus.out_valid);
    end
    n_vec++; if (bus.rd_addr !== '0 || bus.out_data !== 8'sd0) begin n_err++; $display("FAIL rmid_data: got rd_addr %0d out_data %0d want 0 0", bus.rd_addr, bus.out_data); end
    step(); step();
    rst_n = 1'b1;
    step();
    kick(30, 3);
    got = 0; cyc = 0;
    n_vec++; if (bus.rd_addr !== 10'd30) begin n_err++; $display("FAIL rmid_restart_addr: got %0d want 30", bus.rd_addr); end
    while (cyc < 30 && !(busy === 1'b0)) begin
      if (bus.out_valid === 1'b1) begin
        n_vec++; if (bus.out_data !== mem[30 + got]) begin n_err++; $display("FAIL rmid_word_%0d: got %0d want %0d", got, bus.out_data, mem[30 + got]); end
        got++;
      end
      if (done === 1'b1) dones++;
      step();
      cyc++;
    end
    n_vec++; if (got != 3 || dones != 1) begin n_err++; $display("FAIL rmid_restart: got words %0d dones %0d want 3 1", got, dones); end
  endtask

  task automatic test_clear();
    int cyc = 0, hs_cyc = -1, clr_cyc = -1, done_cyc = -1, clears = 0;
    bus.out_ready = 1'b1;
    kick(40, 2);
    while (cyc < 30 && done_cyc < 0) begin
      if (bus.out_valid === 1'b1) hs_cyc = cyc;
      if (clear === 1'b1) begin clears++; clr_cyc = cyc; end
      if (done === 1'b1) done_cyc = cyc;
      step();
      cyc++;
    end
`ifdef ACCUM_DRAIN_CLEAR_EN
    n_vec++; if (clears != 1) begin n_err++; $display("FAIL clr_count: got %0d want 1", clears); end
    n_vec++; if (clr_cyc != hs_cyc + 1) begin n_err++; $display("FAIL clr_timing: got cycle %0d want %0d", clr_cyc, hs_cyc + 1); end
    n_vec++; if (done_cyc != hs_cyc + 2) begin n_err++; $display("FAIL clr_done_timing: got cycle %0d want %0d", done_cyc, hs_cyc + 2); end
`else
    n_vec++; if (clears != 0) begin n_err++; $display("FAIL clr_absent: got %0d clear cycles want 0", clears); end
    n_vec++; if (done_cyc != hs_cyc + 1) begin n_err++; $display("FAIL clr_done_timing: got cycle %0d want %0d", done_cyc, hs_cyc + 1); end
`endif
    step();
  endtask

  initial begin
    for (int i = 0; i < NUM; i++) mem[i] = 8'(i * 37 + 11);
    mem[0] = 8'sd5; mem[1] = -8'sd3; mem[2] = 8'sd127; mem[3] = 8'sh80;
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero();
    test_reset_mid();
    test_clear();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test want finish before 200000");
    $fatal(1, "watchdog expired");
  end
endmodule
